// File: rtl/controle_telas_pkg.sv
// Shared screen encodings, FSM state type and hold default for controle_telas and the screen mux.
// Macro TELAS_PAUSA_EN adds the PAUSA state.
package controle_telas_pkg;

    localparam int HOLD_FRAMES_PADRAO = 180;

    localparam logic [1:0] MODO_INICIAL = 2'd0;
    localparam logic [1:0] MODO_JOGO    = 2'd1;
    localparam logic [1:0] MODO_VITORIA = 2'd2;
    localparam logic [1:0] MODO_DERROTA = 2'd3;

    typedef enum logic [2:0] {
        INICIAL = 3'd0,
        JOGO    = 3'd1,
        VITORIA = 3'd2,
        DERROTA = 3'd3
`ifdef TELAS_PAUSA_EN
        ,
        PAUSA   = 3'd4
`endif
    } estado_t;

    // A paused game keeps showing the game screen.
    function automatic logic [1:0] modo_de(input estado_t e);
        logic [1:0] m;
        m = MODO_INICIAL;
        case (e)
            INICIAL: m = MODO_INICIAL;
            JOGO:    m = MODO_JOGO;
            VITORIA: m = MODO_VITORIA;
            DERROTA: m = MODO_DERROTA;
`ifdef TELAS_PAUSA_EN
            PAUSA:   m = MODO_JOGO;
`endif
            default: m = MODO_INICIAL;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/controle_telas_detector_borda.sv
// Rising-edge detector: registers the previous level, flags a 0->1 change in the same cycle.
module detector_borda (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic borda
);

    logic d_ant;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) d_ant <= 1'b0;
        else        d_ant <= d;
    end

    assign borda = d & ~d_ant;

endmodule

// File: rtl/controle_telas.sv
// Screen controller: start / game / win / loss screens, modo changes only on frame_tick.
// Macro TELAS_PAUSA_EN enables pausing the game with the start button.
module controle_telas
    import controle_telas_pkg::*;
#(
    parameter int HOLD_FRAMES = HOLD_FRAMES_PADRAO
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       inicio,
    input  logic       vitoria_evt,
    input  logic       derrota_evt,
    output logic [1:0] modo,
    output logic       jogo_ativo,
    output logic       troca,
    output estado_t    estado_dbg
);

    localparam int CW = $clog2(HOLD_FRAMES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_FRAMES);

    estado_t       estado, estado_prox;
    logic [CW-1:0] cnt;
    logic          inicio_re;
    logic          tela_fim;

    detector_borda u_borda_inicio (
        .clk   (clk),
        .reset (reset),
        .d     (inicio),
        .borda (inicio_re)
    );

    assign tela_fim   = (estado == VITORIA) || (estado == DERROTA);
    assign estado_dbg = estado;

    // Loss wins over a simultaneous win.
    always_comb begin
        estado_prox = estado;
        case (estado)
            INICIAL: if (inicio_re) estado_prox = JOGO;
            JOGO: begin
                if (derrota_evt)      estado_prox = DERROTA;
                else if (vitoria_evt) estado_prox = VITORIA;
`ifdef TELAS_PAUSA_EN
                else if (inicio_re)   estado_prox = PAUSA;
`endif
            end
            VITORIA, DERROTA: if (inicio_re || cnt == CNT_MAX) estado_prox = INICIAL;
`ifdef TELAS_PAUSA_EN
            PAUSA: if (inicio_re) estado_prox = JOGO;
`endif
            default: estado_prox = INICIAL;
        endcase
    end

    // modo samples the pre-transition state, so an event on a tick cycle shows on the next tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado     <= INICIAL;
            cnt        <= '0;
            modo       <= MODO_INICIAL;
            jogo_ativo <= 1'b0;
            troca      <= 1'b0;
        end else begin
            estado     <= estado_prox;
            jogo_ativo <= (estado_prox == JOGO);
            if (estado_prox != estado)
                cnt <= '0;
            else if (frame_tick && tela_fim && cnt != CNT_MAX)
                cnt <= cnt + CW'(1);
            if (frame_tick) begin
                modo  <= modo_de(estado);
                troca <= (modo_de(estado) != modo);
            end else begin
                troca <= 1'b0;
            end
        end
    end

endmodule

// File: doc/controle_telas.md
CONTROLE_TELAS -- requirements
Module: controle_telas

Interface
REQ-001 SHALL have parameter HOLD_FRAMES, default 180, number of frames an end screen is held before auto-return to the start screen.
REQ-002 SHALL have port clk, input, 1, the single system clock.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port frame_tick, input, 1, one-cycle pulse at the start of vertical blanking.
REQ-005 SHALL have port inicio, input, 1, start button level, already synchronised.
REQ-006 SHALL have port vitoria_evt, input, 1, one-cycle win event from game logic.
REQ-007 SHALL have port derrota_evt, input, 1, one-cycle loss event from game logic.
REQ-008 SHALL have port modo, output, 2, screen select: 0 inicial, 1 jogo, 2 vitoria, 3 derrota.
REQ-009 SHALL have port jogo_ativo, output, 1, high while the game logic may advance.
REQ-010 SHALL have port troca, output, 1, one-cycle pulse on the clock edge where modo changes value.

Function
REQ-011 SHALL implement FSM states INICIAL, JOGO, VITORIA, DERROTA (plus PAUSA, see REQ-024).
REQ-012 SHALL detect an inicio rising edge internally using the registered previous level; the edge (inicio_re) drives transitions, never the level.
REQ-013 INICIAL -> JOGO on inicio_re.
REQ-014 JOGO -> DERROTA on derrota_evt; JOGO -> VITORIA on vitoria_evt; both in the same cycle -> DERROTA.
REQ-015 VITORIA/DERROTA -> INICIAL on inicio_re, or after HOLD_FRAMES frame_tick pulses counted from entry, whichever occurs first.
REQ-016 Frame counter SHALL clear on every state entry, increment only on frame_tick in VITORIA/DERROTA, and saturate; its width is clog2(HOLD_FRAMES+1).
REQ-017 A state transition SHALL take effect on the clock edge after the triggering input (latency 1 cycle).
REQ-018 modo SHALL load the state encoding only on cycles where frame_tick=1, so screen changes never occur mid-frame; an event coinciding with frame_tick is shown on the next frame_tick.
REQ-019 Events not valid in the current state (e.g. vitoria_evt in INICIAL) SHALL be ignored.
REQ-020 jogo_ativo SHALL be registered, high exactly when the state is JOGO, independent of frame_tick.
REQ-021 troca SHALL pulse for one cycle only when the loaded modo differs from its previous value.

Reset
REQ-022 On reset low, state SHALL go to INICIAL, modo=0, jogo_ativo=0, troca=0, counter=0, edge register=0, asynchronously.
REQ-023 Reset asserted mid-game or mid-hold SHALL abandon the current state with no pending modo update after release.

Configuration
REQ-024 With macro TELAS_PAUSA_EN defined: state PAUSA exists; JOGO -> PAUSA on inicio_re and PAUSA -> JOGO on inicio_re; in PAUSA modo remains 1 and jogo_ativo=0; derrota_evt/vitoria_evt are ignored in PAUSA.
REQ-025 Without TELAS_PAUSA_EN: no PAUSA state; inicio_re in JOGO is ignored.

Structure
REQ-026 A shared package SHALL hold the modo encodings (MODO_INICIAL=0, MODO_JOGO=1, MODO_VITORIA=2, MODO_DERROTA=3), the FSM state type and the HOLD_FRAMES default, for reuse by the screen mux.
REQ-027 One sub-module, detector_borda (registered rising-edge detector with async active-low reset), SHALL be instantiated for inicio.

Verification
REQ-028 Reset low, then release with idle inputs for 5 frames -> modo=0, jogo_ativo=0, no troca pulses.
REQ-029 inicio pulse 3 cycles wide in INICIAL -> jogo_ativo=1 one cycle later; modo=1 and troca=1 at the next frame_tick; a held inicio causes no further transition.
REQ-030 In JOGO, vitoria_evt and derrota_evt in the same cycle -> DERROTA; modo=3 at the next frame_tick; jogo_ativo=0 one cycle after the event.
REQ-031 In VITORIA with HOLD_FRAMES=4 and no inicio -> modo returns to 0 on the frame_tick following the 4th counted tick; inicio after 2 ticks -> return on the next frame_tick.
REQ-032 Reset pulsed low while in DERROTA with counter=2 -> immediate modo=0; after release, a full HOLD_FRAMES count is required on the next loss.
REQ-033 With TELAS_PAUSA_EN: inicio in JOGO -> jogo_ativo=0, modo stays 1, derrota_evt ignored; a second inicio -> jogo_ativo=1. Without the macro: inicio in JOGO -> no change.
